// File: rtl/pico_seq_decoder.sv
// pico_seq_decoder
//
// Control decoder for a small sequential CPU. It decodes the opcode and
// drives program-counter, ALU and register-file write controls. Multi-cycle
// instructions (MULTI, IO waits) and the post-branch bubble are handled by a
// four-state FSM (RUN, MUL, IOW, BR).
//
// Ports
//   clk          in   system clock, all state updates on the rising edge
//   n_reset      in   synchronous active-low reset
//   opcode       in   [OPW-1:0] current instruction opcode
//   flags        in   [3:0] ALU flags: [0]=Z, [1]=C, [2]=V, [3]=N
//   ready        in   IO handshake level, already synchronous to clk
//   PCincr       out  advance PC by one
//   PCabsbranch  out  load PC from the branch target
//   ALUfunc      out  [ALUW-1:0] ALU function, the low opcode bits
//   imm          out  ALU B operand comes from the immediate field
//   immsw        out  write-back data comes from the immediate field
//   w            out  register-file write enable
//   busy         out  FSM is outside RUN
//   io_timeout   out  one-cycle pulse when an IO wait gives up
//   illegal      out  one-cycle pulse for an unknown opcode in RUN
//
// IO handshake: ready is a level, not a valid/ready transfer. IO1 completes
// in the first cycle where ready=1, IO2 in the first cycle where ready=0.
// The upstream fetch holds opcode stable for as long as busy=1, except in
// BR, where the opcode is ignored altogether.

module pico_seq_decoder #(
  parameter int OPW        = 6,
  parameter int ALUW       = 3,
  parameter int MUL_CYCLES = 3,
  parameter int IO_TIMEOUT = 255,
  parameter int BR_BUBBLE  = 1
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [OPW-1:0]  opcode,
  input  logic [3:0]      flags,
  input  logic            ready,
  output logic            PCincr,
  output logic            PCabsbranch,
  output logic [ALUW-1:0] ALUfunc,
  output logic            imm,
  output logic            immsw,
  output logic            w,
  output logic            busy,
  output logic            io_timeout,
  output logic            illegal
);

  // Opcode encodings, zero-extended to OPW.
  localparam logic [OPW-1:0] OP_NOP   = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(6'h02);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h0A);
  localparam logic [OPW-1:0] OP_MULTI = OPW'(6'h0C);
  localparam logic [OPW-1:0] OP_LDI   = OPW'(6'h10);
  localparam logic [OPW-1:0] OP_IO1   = OPW'(6'h20);
  localparam logic [OPW-1:0] OP_IO2   = OPW'(6'h21);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'h30);
  localparam logic [OPW-1:0] OP_BZ    = OPW'(6'h31);
  localparam logic [OPW-1:0] OP_BNZ   = OPW'(6'h32);

  // The RUN cycle of a MULTI is the first of MUL_CYCLES, and the final MUL
  // cycle is the one where mcnt reaches zero, hence the "-2".
  localparam logic [3:0]  MCNT_LOAD = 4'(MUL_CYCLES - 2);
  // Last IOW count before giving up; unused when IO_TIMEOUT is 0.
  localparam logic [15:0] IO_LAST   = 16'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_MUL = 2'd1,
    ST_IOW = 2'd2,
    ST_BR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [15:0] iocnt_q, iocnt_d;

  // Per-cycle helpers.
  logic io_cond;   // IO completion condition for the current opcode
  logic take_br;   // a branch in RUN is taken this cycle

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= ST_RUN;
      mcnt_q  <= 4'd0;
      iocnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      iocnt_q <= iocnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mcnt_d      = mcnt_q;
    iocnt_d     = iocnt_q;
    PCincr      = 1'b0;
    PCabsbranch = 1'b0;
    ALUfunc     = opcode[ALUW-1:0];
    imm         = 1'b0;
    immsw       = 1'b0;
    w           = 1'b0;
    io_timeout  = 1'b0;
    illegal     = 1'b0;
    busy        = (state_q != ST_RUN);
    take_br     = 1'b0;
    io_cond     = (opcode == OP_IO1) ? ready : !ready;

    case (state_q)
      ST_RUN: begin
        PCincr = 1'b1;
        case (opcode)
          OP_NOP: ;
          OP_ADD: w = 1'b1;
          OP_ADDI: begin
            w   = 1'b1;
            imm = 1'b1;
          end
          OP_LDI: begin
            w     = 1'b1;
            immsw = 1'b1;
          end
          OP_MULTI: begin
            imm = 1'b1;
            if (MUL_CYCLES == 1) begin
              w = 1'b1;
            end else begin
              PCincr  = 1'b0;
              mcnt_d  = MCNT_LOAD;
              state_d = ST_MUL;
            end
          end
          OP_IO1, OP_IO2: begin
            // Already satisfied: complete in one cycle without waiting.
            if (!io_cond) begin
              PCincr  = 1'b0;
              iocnt_d = 16'd0;
              state_d = ST_IOW;
            end
          end
          OP_J:    take_br = 1'b1;
          OP_BZ:   take_br = flags[0];
          OP_BNZ:  take_br = !flags[0];
          default: illegal = 1'b1;
        endcase

        if (take_br) begin
          PCincr      = 1'b0;
          PCabsbranch = 1'b1;
          if (BR_BUBBLE != 0) state_d = ST_BR;
        end
      end

      ST_MUL: begin
        imm = 1'b1;
        if (mcnt_q != 4'd0) begin
          mcnt_d = mcnt_q - 4'd1;
        end else begin
          w       = 1'b1;
          PCincr  = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_IOW: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (io_cond) begin
          PCincr  = 1'b1;
          state_d = ST_RUN;
        end else if ((IO_TIMEOUT != 0) && (iocnt_q == IO_LAST)) begin
          PCincr     = 1'b1;
          io_timeout = 1'b1;
          state_d    = ST_RUN;
        end else begin
          iocnt_d = iocnt_q + 16'd1;
        end
      end

      ST_BR: begin
        // Bubble: all controls inert, opcode ignored.
        state_d = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase

    // While reset is held, the outputs are forced inert regardless of
    // state. The register itself is cleared at the next edge.
    if (!n_reset) begin
      PCincr      = 1'b0;
      PCabsbranch = 1'b0;
      ALUfunc     = '0;
      imm         = 1'b0;
      immsw       = 1'b0;
      w           = 1'b0;
      io_timeout  = 1'b0;
      illegal     = 1'b0;
      busy        = 1'b0;
    end
  end

  // A cycle can never both increment and branch.
  pc_mutex_a: assert property (@(posedge clk) !(PCincr && PCabsbranch));

endmodule

// File: tb/tb_pico_seq_decoder.sv
// Testbench for pico_seq_decoder (OPW=6, ALUW=3, MUL_CYCLES=3, IO_TIMEOUT=5,
// BR_BUBBLE=1). Inputs change 1 ns after the rising edge, outputs are sampled
// on the falling edge. Each scenario task is a table of per-cycle stimulus
// and required outputs; the required vector is queued as the cycle is driven
// and popped when the output is sampled.

module tb_pico_seq_decoder;

  logic       clk;
  logic       n_reset;
  logic [5:0] opcode;
  logic [3:0] flags;
  logic       ready;
  logic       PCincr;
  logic       PCabsbranch;
  logic [2:0] ALUfunc;
  logic       imm;
  logic       immsw;
  logic       w;
  logic       busy;
  logic       io_timeout;
  logic       illegal;

  int total;
  int bad;

  // Output vector: {busy, PCincr, PCabsbranch, ALUfunc[2:0], imm, immsw, w,
  // io_timeout, illegal}
  logic [10:0] exp_q[$];
  logic [10:0] act_vec;
  assign act_vec = {busy, PCincr, PCabsbranch, ALUfunc, imm, immsw, w,
                    io_timeout, illegal};

  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  fl;
    logic        rdy;
    logic        nr;
    logic [10:0] ex;
  } step_t;

  pico_seq_decoder #(
    .OPW(6), .ALUW(3), .MUL_CYCLES(3), .IO_TIMEOUT(5), .BR_BUBBLE(1)
  ) dut (
    .clk(clk), .n_reset(n_reset), .opcode(opcode), .flags(flags),
    .ready(ready), .PCincr(PCincr), .PCabsbranch(PCabsbranch),
    .ALUfunc(ALUfunc), .imm(imm), .immsw(immsw), .w(w), .busy(busy),
    .io_timeout(io_timeout), .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  // Builds an expected output vector.
  function automatic logic [10:0] ev(input logic b, input logic pci,
      input logic pca, input logic [2:0] alu, input logic im,
      input logic isw, input logic wr, input logic iot, input logic ill);
    return {b, pci, pca, alu, im, isw, wr, iot, ill};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [5:0] op, input logic [3:0] fl,
                       input logic rdy, input logic nr);
    @(posedge clk);
    #1;
    opcode  = op;
    flags   = fl;
    ready   = rdy;
    n_reset = nr;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step_t s [4];
    logic [10:0] want;
    s = '{
      '{6'h0A, 4'h0, 1'b0, 1'b0, ev(0,0,0,3'b000,0,0,0,0,0)},
      '{6'h30, 4'h0, 1'b0, 1'b0, ev(0,0,0,3'b000,0,0,0,0,0)},
      '{6'h0C, 4'h0, 1'b1, 1'b0, ev(0,0,0,3'b000,0,0,0,0,0)},
      '{6'h0A, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b010,1,0,1,0,0)}
    };
    for (int i = 0; i < 4; i++) begin
      drive(s[i].op, s[i].fl, s[i].rdy, s[i].nr);
      exp_q.push_back(s[i].ex);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (act_vec !== want) begin
        bad++;
        $display("FAIL reset step %0d: got %b want %b", i, act_vec, want);
      end
    end
  endtask

  task automatic test_decode();
    step_t s [7];
    logic [10:0] want;
    s = '{
      '{6'h00, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b000,0,0,0,0,0)},
      '{6'h02, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b010,0,0,1,0,0)},
      '{6'h0A, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b010,1,0,1,0,0)},
      '{6'h10, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b000,0,1,1,0,0)},
      '{6'h3F, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b111,0,0,0,0,1)},
      '{6'h01, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b001,0,0,0,0,1)},
      '{6'h0B, 4'h0, 1'b1, 1'b1, ev(0,1,0,3'b011,0,0,0,0,1)}
    };
    for (int i = 0; i < 7; i++) begin
      drive(s[i].op, s[i].fl, s[i].rdy, s[i].nr);
      exp_q.push_back(s[i].ex);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (act_vec !== want) begin
        bad++;
        $display("FAIL decode step %0d: got %b want %b", i, act_vec, want);
      end
    end
  endtask

  task automatic test_multi();
    step_t s [7];
    logic [10:0] want;
    s = '{
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(0,0,0,3'b100,1,0,0,0,0)},
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(1,0,0,3'b100,1,0,0,0,0)},
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(1,1,0,3'b100,1,0,1,0,0)},
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(0,0,0,3'b100,1,0,0,0,0)},
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(1,0,0,3'b100,1,0,0,0,0)},
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(1,1,0,3'b100,1,0,1,0,0)},
      '{6'h00, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b000,0,0,0,0,0)}
    };
    for (int i = 0; i < 7; i++) begin
      drive(s[i].op, s[i].fl, s[i].rdy, s[i].nr);
      exp_q.push_back(s[i].ex);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (act_vec !== want) begin
        bad++;
        $display("FAIL multi step %0d: got %b want %b", i, act_vec, want);
      end
    end
  endtask

  task automatic test_io_wait();
    step_t s [7];
    logic [10:0] want;
    s = '{
      '{6'h20, 4'h0, 1'b0, 1'b1, ev(0,0,0,3'b000,0,0,0,0,0)},
      '{6'h20, 4'h0, 1'b0, 1'b1, ev(1,0,0,3'b000,0,0,0,0,0)},
      '{6'h20, 4'h0, 1'b0, 1'b1, ev(1,0,0,3'b000,0,0,0,0,0)},
      '{6'h20, 4'h0, 1'b0, 1'b1, ev(1,0,0,3'b000,0,0,0,0,0)},
      '{6'h20, 4'h0, 1'b1, 1'b1, ev(1,1,0,3'b000,0,0,0,0,0)},
      '{6'h20, 4'h0, 1'b1, 1'b1, ev(0,1,0,3'b000,0,0,0,0,0)},
      '{6'h00, 4'h0, 1'b1, 1'b1, ev(0,1,0,3'b000,0,0,0,0,0)}
    };
    for (int i = 0; i < 7; i++) begin
      drive(s[i].op, s[i].fl, s[i].rdy, s[i].nr);
      exp_q.push_back(s[i].ex);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (act_vec !== want) begin
        bad++;
        $display("FAIL io_wait step %0d: got %b want %b", i, act_vec, want);
      end
    end
  endtask

  // IO2 with ready stuck high times out on the IOW cycle where iocnt=4;
  // the second run drops ready on exactly that cycle, so completion wins.
  task automatic test_io_timeout();
    step_t s [15];
    logic [10:0] want;
    s = '{
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(0,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(1,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(1,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(1,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(1,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(1,1,0,3'b001,0,0,0,1,0)},
      '{6'h21, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(0,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(1,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(1,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(1,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b1, 1'b1, ev(1,0,0,3'b001,0,0,0,0,0)},
      '{6'h21, 4'h0, 1'b0, 1'b1, ev(1,1,0,3'b001,0,0,0,0,0)},
      '{6'h00, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b000,0,0,0,0,0)},
      '{6'h00, 4'h0, 1'b1, 1'b1, ev(0,1,0,3'b000,0,0,0,0,0)}
    };
    for (int i = 0; i < 15; i++) begin
      drive(s[i].op, s[i].fl, s[i].rdy, s[i].nr);
      exp_q.push_back(s[i].ex);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (act_vec !== want) begin
        bad++;
        $display("FAIL io_timeout step %0d: got %b want %b", i, act_vec, want);
      end
    end
  endtask

  task automatic test_branch();
    step_t s [10];
    logic [10:0] want;
    s = '{
      '{6'h31, 4'b0001, 1'b0, 1'b1, ev(0,0,1,3'b001,0,0,0,0,0)},
      '{6'h31, 4'b0001, 1'b0, 1'b1, ev(1,0,0,3'b001,0,0,0,0,0)},
      '{6'h32, 4'b0001, 1'b0, 1'b1, ev(0,1,0,3'b010,0,0,0,0,0)},
      '{6'h31, 4'b0000, 1'b0, 1'b1, ev(0,1,0,3'b001,0,0,0,0,0)},
      '{6'h31, 4'b1110, 1'b0, 1'b1, ev(0,1,0,3'b001,0,0,0,0,0)},
      '{6'h32, 4'b0000, 1'b0, 1'b1, ev(0,0,1,3'b010,0,0,0,0,0)},
      '{6'h02, 4'b0000, 1'b0, 1'b1, ev(1,0,0,3'b010,0,0,0,0,0)},
      '{6'h30, 4'b0001, 1'b0, 1'b1, ev(0,0,1,3'b000,0,0,0,0,0)},
      '{6'h3F, 4'b0000, 1'b0, 1'b1, ev(1,0,0,3'b111,0,0,0,0,0)},
      '{6'h02, 4'b0000, 1'b0, 1'b1, ev(0,1,0,3'b010,0,0,1,0,0)}
    };
    for (int i = 0; i < 10; i++) begin
      drive(s[i].op, s[i].fl, s[i].rdy, s[i].nr);
      exp_q.push_back(s[i].ex);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (act_vec !== want) begin
        bad++;
        $display("FAIL branch step %0d: got %b want %b", i, act_vec, want);
      end
    end
  endtask

  // Reset asserted in the middle of MUL (mcnt=1), IOW and BR.
  task automatic test_reset_mid_state();
    step_t s [13];
    logic [10:0] want;
    s = '{
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(0,0,0,3'b100,1,0,0,0,0)},
      '{6'h0C, 4'h0, 1'b0, 1'b0, ev(0,0,0,3'b000,0,0,0,0,0)},
      '{6'h3F, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b111,0,0,0,0,1)},
      '{6'h20, 4'h0, 1'b0, 1'b1, ev(0,0,0,3'b000,0,0,0,0,0)},
      '{6'h20, 4'h0, 1'b0, 1'b1, ev(1,0,0,3'b000,0,0,0,0,0)},
      '{6'h20, 4'h0, 1'b0, 1'b0, ev(0,0,0,3'b000,0,0,0,0,0)},
      '{6'h00, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b000,0,0,0,0,0)},
      '{6'h30, 4'h0, 1'b0, 1'b1, ev(0,0,1,3'b000,0,0,0,0,0)},
      '{6'h30, 4'h0, 1'b0, 1'b0, ev(0,0,0,3'b000,0,0,0,0,0)},
      '{6'h10, 4'h0, 1'b0, 1'b1, ev(0,1,0,3'b000,0,1,1,0,0)},
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(0,0,0,3'b100,1,0,0,0,0)},
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(1,0,0,3'b100,1,0,0,0,0)},
      '{6'h0C, 4'h0, 1'b0, 1'b1, ev(1,1,0,3'b100,1,0,1,0,0)}
    };
    for (int i = 0; i < 13; i++) begin
      drive(s[i].op, s[i].fl, s[i].rdy, s[i].nr);
      exp_q.push_back(s[i].ex);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (act_vec !== want) begin
        bad++;
        $display("FAIL reset_mid step %0d: got %b want %b", i, act_vec, want);
      end
    end
  endtask

  // Random stream of single-cycle instructions issued back to back.
  task automatic test_back_to_back();
    logic [5:0]  ops [7];
    logic [3:0]  fls [7];
    logic [10:0] exs [7];
    logic [10:0] want;
    int k;
    ops = '{6'h00, 6'h02, 6'h0A, 6'h10, 6'h3F, 6'h31, 6'h32};
    fls = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0001};
    exs = '{ev(0,1,0,3'b000,0,0,0,0,0), ev(0,1,0,3'b010,0,0,1,0,0),
            ev(0,1,0,3'b010,1,0,1,0,0), ev(0,1,0,3'b000,0,1,1,0,0),
            ev(0,1,0,3'b111,0,0,0,0,1), ev(0,1,0,3'b001,0,0,0,0,0),
            ev(0,1,0,3'b010,0,0,0,0,0)};
    for (int i = 0; i < 24; i++) begin
      k = int'($urandom_range(0, 6));
      drive(ops[k], fls[k], 1'($urandom_range(0, 1)), 1'b1);
      exp_q.push_back(exs[k]);
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (act_vec !== want) begin
        bad++;
        $display("FAIL back_to_back step %0d op %h: got %b want %b",
                 i, ops[k], act_vec, want);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total   = 0;
    bad     = 0;
    n_reset = 1'b0;
    opcode  = 6'h0A;
    flags   = 4'h0;
    ready   = 1'b0;

    test_reset();
    test_decode();
    test_multi();
    test_io_wait();
    test_io_timeout();
    test_branch();
    test_reset_mid_state();
    test_back_to_back();

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pico_seq_decoder.md
PICO_SEQ_DECODER -- requirements
Module: pico_seq_decoder

Interface
REQ-001 Parameter OPW, default 6: opcode width; SHALL be >= ALUW+3.
REQ-002 Parameter ALUW, default 3: ALU function width; ALUfunc = opcode[ALUW-1:0] for every opcode.
REQ-003 Parameter MUL_CYCLES, default 3, range 1..15: total cycles a MULTI occupies.
REQ-004 Parameter IO_TIMEOUT, default 255, range 0..65535: maximum IO wait cycles; 0 = wait forever.
REQ-005 Parameter BR_BUBBLE, default 1, range 0..1: inert cycles after any taken branch.
REQ-006 Ports, in order: clk in 1 (system clock); n_reset in 1 (synchronous, active-low reset); opcode in OPW; flags in 4 ([0]=Z,[1]=C,[2]=V,[3]=N); ready in 1 (IO handshake, already synchronous to clk); PCincr out 1; PCabsbranch out 1; ALUfunc out ALUW; imm out 1; immsw out 1; w out 1; busy out 1 (state != RUN); io_timeout out 1 (one-cycle pulse); illegal out 1 (one-cycle pulse).
REQ-007 Opcode encodings (OPW=6, left-zero-extended for larger OPW): NOP 0x00, ADD 0x02, ADDI 0x0A, MULTI 0x0C, LDI 0x10, IO1 0x20, IO2 0x21, J 0x30, BZ 0x31, BNZ 0x32.

Function
REQ-010 One clock, clk; all state updates on rising edge only; reset is synchronous, active-low, on n_reset.
REQ-011 States: RUN, MUL, IOW, BR; outputs are combinational from state, opcode, flags, ready, counters.
REQ-012 Inert output set: PCincr=0, PCabsbranch=0, imm=0, immsw=0, w=0, io_timeout=0, illegal=0.
REQ-013 RUN default for any opcode: PCincr=1, others 0 unless stated below.
REQ-014 ADD: w=1. ADDI: w=1, imm=1. LDI: w=1, immsw=1. NOP: defaults only.
REQ-015 MULTI, MUL_CYCLES=1: imm=1, w=1, PCincr=1, stay RUN.
REQ-016 MULTI, MUL_CYCLES>1: in RUN imm=1, w=0, PCincr=0, load mcnt=MUL_CYCLES-2, go MUL.
REQ-017 MUL: imm=1, ALUfunc from opcode; if mcnt!=0 then w=0, PCincr=0, mcnt decrements; if mcnt==0 then w=1, PCincr=1, go RUN.
REQ-018 IO1 waits for ready=1, IO2 for ready=0: in RUN, if condition met then PCincr=1, stay RUN; else PCincr=0, clear iocnt, go IOW.
REQ-019 IOW: opcode held stable by upstream; condition met -> PCincr=1, go RUN; else if IO_TIMEOUT!=0 and iocnt==IO_TIMEOUT-1 -> PCincr=1, io_timeout=1, go RUN; else PCincr=0, iocnt increments (16-bit, no wrap reachable).
REQ-020 Condition met and timeout in the same IOW cycle: condition wins, io_timeout=0.
REQ-021 J: PCabsbranch=1, PCincr=0; go BR if BR_BUBBLE=1, else stay RUN.
REQ-022 BZ taken iff flags[0]=1, BNZ taken iff flags[0]=0; taken -> as J; not taken -> PCincr=1, stay RUN.
REQ-023 BR: inert outputs for exactly one cycle, opcode ignored, go RUN.
REQ-024 Opcode not in REQ-007 in RUN: treated as NOP, illegal=1 for that cycle.
REQ-025 busy=1 in MUL, IOW, BR; 0 in RUN.
REQ-026 PCincr and PCabsbranch SHALL never both be 1.

Reset
REQ-030 n_reset=0 at a rising edge: state=RUN, mcnt=0, iocnt=0, regardless of current state (mid-MUL, mid-IOW, BR).
REQ-031 While n_reset=0, all outputs forced to the inert set, busy=0, ALUfunc=0.
REQ-032 First cycle after n_reset returns high: normal RUN decode of current opcode.

Verification
REQ-040 ADDI 0x0A, n_reset=1 -> ALUfunc=3'b010, w=1, imm=1, PCincr=1, busy=0, illegal=0.
REQ-041 MULTI 0x0C, MUL_CYCLES=3 -> cycle0 w=0 PCincr=0; cycle1 busy=1 w=0; cycle2 w=1 PCincr=1; cycle3 busy=0.
REQ-042 IO1, ready=0 for 4 cycles then 1 -> PCincr=0 cycles 0..3, PCincr=1 cycle 4, io_timeout=0 throughout.
REQ-043 IO2, IO_TIMEOUT=5, ready held 1 -> PCincr=1 and io_timeout=1 on first cycle where iocnt=4, then RUN.
REQ-044 BZ with flags=4'b0001, BR_BUBBLE=1 -> PCabsbranch=1 PCincr=0, next cycle inert with busy=1; BNZ same flags -> PCincr=1 only.
REQ-045 n_reset=0 at edge during MUL (mcnt=1) -> next cycle busy=0, outputs inert; opcode 0x3F after release -> illegal=1, PCincr=1.
